alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Execution-side consumer of the 3-bit ALU opcode produced by the instruction decode stage. It accepts one operation at a time through a valid/ready handshake, computes an 8-bit result plus N/Z/C/V flags, and holds them until the downstream stage (register writeback / flag register) accepts. Shifts may be executed bit-serially, making latency opcode-dependent.

## Interface
- `WIDTH`, 8, datapath width in bits; only 8 is supported.
- `clk`  input  1  single clock, all state on rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `in_valid`  input  1  operation request.
- `in_ready`  output  1  unit can accept; equals (state == IDLE).
- `alu_opcode`  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 LSL, 111 LSR.
- `op_a`  input  WIDTH  first operand.
- `op_b`  input  WIDTH  second operand; for shifts only `op_b[2:0]` (shift count) is used.
- `out_valid`  output  1  result and flags are valid.
- `out_ready`  input  1  downstream accepts result.
- `result`  output  WIDTH  registered result.
- `flags`  output  4  registered {N, Z, C, V}.
- `busy`  output  1  state != IDLE.

## Operation
- States: IDLE, SHIFT, DONE. Reset state IDLE.
- IDLE: on `in_valid && in_ready`, capture opcode and operands; later input changes are ignored.
  - Non-shift op, or shift with count 0: compute result, go to DONE.
  - Shift with count 1..7 (macro enabled): load working register with `op_a`, counter with count, go to SHIFT.
- SHIFT: each cycle shift one bit (LSL: zero into bit 0; LSR: zero into bit 7), C = bit shifted out, decrement counter; when counter reaches 0 after the shift, go to DONE.
- DONE: `out_valid` = 1; `result`/`flags` stable. On `out_ready`, go to IDLE. No new request accepted in DONE (single outstanding op).
- Arithmetic: ADD {C,res} = a + b, V = signed overflow. SUB res = a − b mod 256, C = 1 when borrow (a < b unsigned), V = signed overflow. AND/OR/XOR/NOT: C = 0, V = 0; NOT = ~a, `op_b` ignored. Shifts: V = 0; count 0 → res = a, C = 0.
- N = res[7], Z = (res == 0) for all ops.
- `result`/`flags` update only on entry to DONE; they persist after handshake until the next completion.

## Timing
- Reset values: `result` = 0, `flags` = 0, `out_valid` = 0, `busy` = 0, `in_ready` = 1.
- Non-shift latency: accept at edge N, `out_valid` high after edge N (visible cycle N+1).
- Serial shift by k: `out_valid` visible k+1 cycles after accept.
- Back-to-back: after `out_valid && out_ready` at edge M, `in_ready` is 1 in cycle M+1; minimum issue interval 2 cycles.
- `rst_n` asserted mid-operation: immediately abort, return to IDLE, clear all outputs; no partial result is reported.

## Configuration
- `ALU_SERIAL_SHIFT_EN` defined: shifts use SHIFT state, one bit per cycle, as above.
- Not defined: shifts use a single-cycle barrel shifter, same latency as other ops; SHIFT state and counter are absent; C = last bit shifted out (same value as serial mode).

## Structure
- Shared package `opcode_pkg`: add enum `alu_op_t` (ALU_ADD … ALU_LSR, 3 bits) and state enum `alu_exec_state_t`; decoder and this block both use `alu_op_t`.
- Sub-module `alu_flag_gen`: combinational N/Z/C/V from result, carry and overflow inputs.

## Test plan
- ADD 0x7F + 0x01 → result 0x80, flags N=1 Z=0 C=0 V=1, `out_valid` one cycle after accept.
- SUB 0x05 − 0x05 → 0x00, Z=1 C=0; SUB 0x00 − 0x01 → 0xFF, N=1 C=1 V=0.
- LSR 0x0D by 3 → 0x01, C=1; `out_valid` 4 cycles after accept with macro, 1 cycle without. LSL 0x81 by 0 → 0x81, C=0, 1-cycle latency.
- Backpressure: hold `out_ready` = 0 for 5 cycles with `in_valid` = 1 → `result`/`flags` stable, `in_ready` = 0, no second op accepted; release → IDLE next cycle, new op accepted.
- Assert `rst_n` low during SHIFT of LSL 0xFF by 7 → outputs 0, `in_ready` 1 after release, no `out_valid`.
- NOT 0x00 with `op_b` = 0xAA → 0xFF, N=1 C=0 V=0; flags unchanged across following idle cycles.

Source files
------------

// File: rtl/opcode_pkg.sv
// Shared opcode/state definitions for the decode stage and the ALU execution unit.
//   alu_op_t          : 3-bit ALU opcode as produced by instruction decode
//   alu_exec_state_t  : control states of alu_exec_unit
//   is_shift_op()     : true for LSL/LSR
package opcode_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_NOT = 3'b101,
    ALU_LSL = 3'b110,
    ALU_LSR = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_exec_state_t;

  function automatic logic is_shift_op(input alu_op_t op);
    return (op == ALU_LSL) || (op == ALU_LSR);
  endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational condition-flag generator.
// Ports:
//   res      in  WIDTH  result value
//   carry    in  1      carry/borrow/shift-out bit
//   overflow in  1      signed overflow
//   flags    out 4      {N, Z, C, V}
module alu_flag_gen #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] res,
  input  logic             carry,
  input  logic             overflow,
  output logic [3:0]       flags
);

  always_comb begin
    flags = {res[WIDTH-1], (res == '0), carry, overflow};
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: accepts one opcode/operand set via valid/ready, computes an
// 8-bit result with {N,Z,C,V} flags and holds them until downstream accepts.
// Configuration macro: ALU_SERIAL_SHIFT_EN -- when defined, shifts with a non-zero
// count run one bit per cycle in the SHIFT state; otherwise a single-cycle barrel
// shifter is used and all ops share the same latency.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid / in_ready  request handshake (in_ready = IDLE)
//   alu_opcode           3-bit opcode (alu_op_t encoding)
//   op_a, op_b           operands; shifts use op_b[2:0] as count
//   out_valid/out_ready  result handshake (out_valid = DONE)
//   result, flags        registered result and {N,Z,C,V}
//   busy                 state != IDLE
module alu_exec_unit
  import opcode_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_opcode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy
);

  alu_exec_state_t state_q, state_d;
  alu_op_t         op;
  logic [2:0]      shamt;
  logic [WIDTH:0]  wide;
  logic [WIDTH-1:0] calc_res;
  logic            calc_c, calc_v;
  logic [WIDTH-1:0] fl_res;
  logic            fl_c, fl_v;
  logic [3:0]      fl_flags;
  logic            load_done;

  // Single-cycle datapath, evaluated on the live inputs while IDLE.
  always_comb begin
    op       = alu_op_t'(alu_opcode);
    shamt    = op_b[2:0];
    wide     = '0;
    calc_res = '0;
    calc_c   = 1'b0;
    calc_v   = 1'b0;
    case (op)
      ALU_ADD: begin
        wide     = {1'b0, op_a} + {1'b0, op_b};
        calc_res = wide[WIDTH-1:0];
        calc_c   = wide[WIDTH];
        calc_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (calc_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_SUB: begin
        // Bit WIDTH of the extended difference is the borrow (a < b unsigned).
        wide     = {1'b0, op_a} - {1'b0, op_b};
        calc_res = wide[WIDTH-1:0];
        calc_c   = wide[WIDTH];
        calc_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (calc_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_AND: calc_res = op_a & op_b;
      ALU_OR:  calc_res = op_a | op_b;
      ALU_XOR: calc_res = op_a ^ op_b;
      ALU_NOT: calc_res = ~op_a;
      ALU_LSL, ALU_LSR: begin
`ifdef ALU_SERIAL_SHIFT_EN
        // Only a zero count finishes from IDLE in serial mode.
        calc_res = op_a;
`else
        // Extra bit beside the operand catches the last bit shifted out.
        if (op == ALU_LSL) begin
          wide     = {1'b0, op_a} << shamt;
          calc_res = wide[WIDTH-1:0];
          calc_c   = wide[WIDTH];
        end else begin
          wide     = {op_a, 1'b0} >> shamt;
          calc_res = wide[WIDTH:1];
          calc_c   = wide[0];
        end
`endif
      end
      default: ;
    endcase
  end

`ifdef ALU_SERIAL_SHIFT_EN
  logic [WIDTH-1:0] work_q, step_res;
  logic [2:0]       cnt_q;
  logic             lsl_q, step_c, load_shift;

  always_comb begin
    step_res = '0;
    step_c   = 1'b0;
    if (lsl_q) {step_c, step_res} = {work_q, 1'b0};
    else       {step_res, step_c} = {1'b0, work_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q <= '0;
      cnt_q  <= '0;
      lsl_q  <= 1'b0;
    end else if (load_shift) begin
      work_q <= op_a;
      cnt_q  <= shamt;
      lsl_q  <= (op == ALU_LSL);
    end else if (state_q == ST_SHIFT) begin
      work_q <= step_res;
      cnt_q  <= cnt_q - 3'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_done = 1'b0;
    fl_res    = calc_res;
    fl_c      = calc_c;
    fl_v      = calc_v;
`ifdef ALU_SERIAL_SHIFT_EN
    load_shift = 1'b0;
`endif
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d   = ST_DONE;
          load_done = 1'b1;
`ifdef ALU_SERIAL_SHIFT_EN
          if (is_shift_op(op) && (shamt != 3'd0)) begin
            state_d    = ST_SHIFT;
            load_done  = 1'b0;
            load_shift = 1'b1;
          end
`endif
        end
      end
`ifdef ALU_SERIAL_SHIFT_EN
      ST_SHIFT: begin
        // Flags reflect the final step: C is the last bit shifted out, V stays 0.
        fl_res = step_res;
        fl_c   = step_c;
        fl_v   = 1'b0;
        if (cnt_q == 3'd1) begin
          state_d   = ST_DONE;
          load_done = 1'b1;
        end
      end
`endif
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .res      (fl_res),
    .carry    (fl_c),
    .overflow (fl_v),
    .flags    (fl_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      flags  <= '0;
    end else if (load_done) begin
      result <= fl_res;
      flags  <= fl_flags;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: reference model results are queued when an
// operation is issued and popped when the unit presents its result.
module tb_alu_exec_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] alu_opcode = 3'd0;
  logic [7:0] op_a = 8'd0;
  logic [7:0] op_b = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] result;
  logic [3:0] flags;
  logic       busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] res;
    logic [3:0] flg;
    int         lat;
  } exp_t;

  exp_t sb[$];

  alu_exec_unit #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_opcode (alu_opcode),
    .op_a       (op_a),
    .op_b       (op_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .flags      (flags),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   ua, ub, sa, sb_, s;
    logic [7:0] r;
    logic c, v;
    int   cnt;
    ua = int'(a); ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb_ = (ub > 127) ? ub - 256 : ub;
    c = 1'b0; v = 1'b0; r = 8'd0;
    cnt = int'(b[2:0]);
    e.lat = 1;
    case (op)
      3'd0: begin s = ua + ub; r = s[7:0]; c = (s > 255); v = ((sa + sb_) > 127) || ((sa + sb_) < -128); end
      3'd1: begin s = ua - ub + 256; r = s[7:0]; c = (ua < ub); v = ((sa - sb_) > 127) || ((sa - sb_) < -128); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      default: begin
        r = a;
        for (int i = 0; i < cnt; i++) begin
          if (op == 3'd6) begin c = r[7]; r = {r[6:0], 1'b0}; end
          else            begin c = r[0]; r = {1'b0, r[7:1]}; end
        end
`ifdef ALU_SERIAL_SHIFT_EN
        if (cnt != 0) e.lat = cnt + 1;
`endif
      end
    endcase
    e.res = r;
    e.flg = {r[7], (r == 8'd0), c, v};
    return e;
  endfunction

  // Issue one op, observe its completion, then complete the output handshake.
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic got, output logic [7:0] res, output logic [3:0] flg,
                        output int lat);
    int guard;
    in_valid = 1'b1; alu_opcode = op; op_a = a; op_b = b;
    sb.push_back(model(op, a, b));
    guard = 0;
    while (!in_ready && guard < 40) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_opcode = 3'($urandom); op_a = 8'($urandom); op_b = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    got = out_valid; res = result; flg = flags;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (result !== 8'h00)  begin failures++; $display("FAIL reset_result got=%h exp=00", result); end
    checks++; if (flags !== 4'h0)    begin failures++; $display("FAIL reset_flags got=%h exp=0", flags); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_ops();
    logic [18:0] vecs [14] = '{
      {3'd0, 8'h7F, 8'h01}, {3'd0, 8'hFF, 8'h01}, {3'd1, 8'h05, 8'h05}, {3'd1, 8'h00, 8'h01},
      {3'd1, 8'h80, 8'h01}, {3'd2, 8'hCC, 8'hAA}, {3'd3, 8'h0C, 8'h30}, {3'd4, 8'hFF, 8'hFF},
      {3'd7, 8'h0D, 8'h03}, {3'd7, 8'h0D, 8'hFB}, {3'd6, 8'h81, 8'h00}, {3'd6, 8'h81, 8'h01},
      {3'd6, 8'h40, 8'h07}, {3'd7, 8'h80, 8'h07}
    };
    logic got; logic [7:0] res; logic [3:0] flg; int lat; exp_t e;
    for (int i = 0; i < 14; i++) begin
      logic [18:0] v;
      v = vecs[i];
      run_op(v[18:16], v[15:8], v[7:0], got, res, flg, lat);
      e = sb.pop_front();
      checks++;
      if (!got) begin failures++; $display("FAIL op%0d_timeout got=no_out_valid exp=out_valid", i); end
      checks++; if (res !== e.res) begin failures++; $display("FAIL op%0d_result got=%h exp=%h", i, res, e.res); end
      checks++; if (flg !== e.flg) begin failures++; $display("FAIL op%0d_flags got=%b exp=%b", i, flg, e.flg); end
      checks++; if (lat != e.lat)  begin failures++; $display("FAIL op%0d_latency got=%0d exp=%0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_not_hold();
    logic got; logic [7:0] res; logic [3:0] flg; int lat; exp_t e;
    run_op(3'd5, 8'h00, 8'hAA, got, res, flg, lat);
    e = sb.pop_front();
    checks++; if (!got || res !== e.res) begin failures++; $display("FAIL not_result got=%h exp=%h", res, e.res); end
    checks++; if (flg !== e.flg) begin failures++; $display("FAIL not_flags got=%b exp=%b", flg, e.flg); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (result !== e.res || flags !== e.flg) begin
        failures++; $display("FAIL not_idle_hold got=%h/%b exp=%h/%b", result, flags, e.res, e.flg);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e1, e2;
    int guard;
    in_valid = 1'b1; alu_opcode = 3'd0; op_a = 8'h10; op_b = 8'h20;
    sb.push_back(model(3'd0, 8'h10, 8'h20));
    guard = 0;
    while (!in_ready && guard < 40) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    alu_opcode = 3'd4; op_a = 8'hF0; op_b = 8'h0F;
    sb.push_back(model(3'd4, 8'hF0, 8'h0F));
    e1 = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== e1.res || flags !== e1.flg) begin
        failures++;
        $display("FAIL bp_hold%0d got=v%b r%b %h/%b exp=v1 r0 %h/%b", i, out_valid, in_ready, result, flags, e1.res, e1.flg);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=r%b v%b exp=r1 v0", in_ready, out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    e2 = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || result !== e2.res || flags !== e2.flg) begin
      failures++; $display("FAIL bp_second got=v%b %h/%b exp=v1 %h/%b", out_valid, result, flags, e2.res, e2.flg);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e1, e2;
    int guard;
    out_ready = 1'b1;
    in_valid = 1'b1; alu_opcode = 3'd1; op_a = 8'h30; op_b = 8'h50;
    sb.push_back(model(3'd1, 8'h30, 8'h50));
    guard = 0;
    while (!in_ready && guard < 40) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    alu_opcode = 3'd3; op_a = 8'h00; op_b = 8'h00;
    sb.push_back(model(3'd3, 8'h00, 8'h00));
    e1 = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || result !== e1.res || flags !== e1.flg) begin
      failures++; $display("FAIL b2b_first got=v%b %h/%b exp=v1 %h/%b", out_valid, result, flags, e1.res, e1.flg);
    end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL b2b_gap got=r%b v%b exp=r1 v0", in_ready, out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    e2 = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || result !== e2.res || flags !== e2.flg) begin
      failures++; $display("FAIL b2b_second got=v%b %h/%b exp=v1 %h/%b", out_valid, result, flags, e2.res, e2.flg);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int guard, seen;
    in_valid = 1'b1; alu_opcode = 3'd6; op_a = 8'hFF; op_b = 8'h07;
    guard = 0;
    while (!in_ready && guard < 40) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (result !== 8'h00 || flags !== 4'h0) begin failures++; $display("FAIL rstmid_clear got=%h/%b exp=00/0000", result, flags); end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ctrl got=v%b b%b r%b exp=v0 b0 r1", out_valid, busy, in_ready); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL rstmid_no_result got=%0d exp=0", seen); end
    checks++; if (in_ready !== 1'b1 || result !== 8'h00) begin failures++; $display("FAIL rstmid_after got=r%b %h exp=r1 00", in_ready, result); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_ops();
    test_not_hold();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
